branch_predictor: RTL and testbench

Parametrised branch predictor and target buffer for the next-generation RV32I pipeline. IF looks up the fetch PC and gets a next-PC prediction in the same cycle. EX returns the resolved outcome, and the block trains its tables and reports mispredict plus the redirect PC. This replaces the fixed always-not-taken, flush-on-taken scheme with configurable depth, counter width and mode, and adds performance counters.

---
 rtl/branch_predictor_if.sv | 48 ++++
 rtl/branch_predictor.sv | 124 ++++++++++++
 tb/tb_branch_predictor.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch-lookup and execute-update bus between the pipeline and the branch predictor.
// Ports (pipeline = master, predictor = slave):
//   pc_if_i            fetch PC to look up
//   pred_taken_o       predicted taken for pc_if_i
//   pred_target_o      predicted next PC for pc_if_i
//   upd_valid_i        EX holds a valid, non-flushed instruction
//   upd_pc_i           PC of the EX instruction
//   upd_is_branch_i    conditional branch
//   upd_is_jump_i      JAL/JALR
//   upd_taken_i        resolved taken
//   upd_target_i       resolved target
//   upd_pred_taken_i   fetch-time prediction carried down the pipe
//   upd_pred_target_i  fetch-time predicted next PC carried down the pipe
//   mispredict_o       EX must redirect and flush
//   redirect_pc_o      correct next PC
//   branch_cnt_o       resolved branch/jump count
//   mispred_cnt_o      mispredict count
interface branch_predictor_if;
   logic [31:0] pc_if_i;
   logic        pred_taken_o;
   logic [31:0] pred_target_o;
   logic        upd_valid_i;
   logic [31:0] upd_pc_i;
   logic        upd_is_branch_i;
   logic        upd_is_jump_i;
   logic        upd_taken_i;
   logic [31:0] upd_target_i;
   logic        upd_pred_taken_i;
   logic [31:0] upd_pred_target_i;
   logic        mispredict_o;
   logic [31:0] redirect_pc_o;
   logic [31:0] branch_cnt_o;
   logic [31:0] mispred_cnt_o;

   modport master (
      output pc_if_i, upd_valid_i, upd_pc_i, upd_is_branch_i, upd_is_jump_i, upd_taken_i,
             upd_target_i, upd_pred_taken_i, upd_pred_target_i,
      input  pred_taken_o, pred_target_o, mispredict_o, redirect_pc_o, branch_cnt_o,
             mispred_cnt_o
   );

   modport slave (
      input  pc_if_i, upd_valid_i, upd_pc_i, upd_is_branch_i, upd_is_jump_i, upd_taken_i,
             upd_target_i, upd_pred_taken_i, upd_pred_target_i,
      output pred_taken_o, pred_target_o, mispredict_o, redirect_pc_o, branch_cnt_o,
             mispred_cnt_o
   );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor with target buffer and saturating direction counters.
// Fetch looks up pc_if_i combinationally; EX resolves, trains the tables, flags a
// mispredict with the redirect PC, and bumps the performance counters.
// Ports:
//   clk_i   clock, all state changes on the rising edge
//   rst_ni  synchronous active-low reset
//   bp      lookup/update bus (slave side), see branch_predictor_if
module branch_predictor #(
   parameter int unsigned ENTRIES   = 16,
   parameter int unsigned TAG_W     = 8,
   parameter int unsigned CTR_W     = 2,
   parameter bit          PRED_MODE = 1'b1
) (
   input logic               clk_i,
   input logic               rst_ni,
   branch_predictor_if.slave bp
);

   localparam int unsigned      IDX_W    = $clog2(ENTRIES);
   localparam logic [CTR_W-1:0] CTR_MAX  = '1;
   localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1 << (CTR_W - 1));

   logic [ENTRIES-1:0] valid_q;
   logic [ENTRIES-1:0] jmp_q;
   logic [TAG_W-1:0]   tag_q [ENTRIES];
   logic [29:0]        tgt_q [ENTRIES];
   logic [CTR_W-1:0]   ctr_q [ENTRIES];
   logic [31:0]        branch_cnt_q;
   logic [31:0]        mispred_cnt_q;

   // ---------------- lookup ----------------
   logic [IDX_W-1:0] l_idx;
   logic [TAG_W-1:0] l_tag;
   logic             l_hit;
   logic             l_taken;

   assign l_idx   = bp.pc_if_i[IDX_W+1:2];
   assign l_tag   = bp.pc_if_i[IDX_W+TAG_W+1:IDX_W+2];
   assign l_hit   = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
   assign l_taken = PRED_MODE && l_hit && (jmp_q[l_idx] || ctr_q[l_idx][CTR_W-1]);

   assign bp.pred_taken_o  = l_taken;
   assign bp.pred_target_o = l_taken ? {tgt_q[l_idx], 2'b00} : bp.pc_if_i + 32'd4;

   // ---------------- resolve ----------------
   logic [IDX_W-1:0] u_idx;
   logic [TAG_W-1:0] u_tag;
   logic             u_hit;
   logic             u_ctrl;
   logic             u_stale;
   logic             u_train;
   logic [31:0]      u_seq_pc;
   logic [31:0]      u_actual;
   logic             u_misp;
   logic [CTR_W-1:0] ctr_cur;
   logic [CTR_W-1:0] ctr_nxt;
   logic [CTR_W-1:0] ctr_alloc;

   assign u_idx    = bp.upd_pc_i[IDX_W+1:2];
   assign u_tag    = bp.upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];
   assign u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
   assign u_ctrl   = bp.upd_valid_i && (bp.upd_is_branch_i || bp.upd_is_jump_i);
   // A non-control instruction that fetch predicted taken hit a stale entry.
   assign u_stale  = bp.upd_valid_i && !bp.upd_is_branch_i && !bp.upd_is_jump_i &&
                     bp.upd_pred_taken_i;
   assign u_train  = u_ctrl && PRED_MODE;
   assign u_seq_pc = bp.upd_pc_i + 32'd4;
   assign u_actual = bp.upd_taken_i ? bp.upd_target_i : u_seq_pc;
   assign u_misp   = bp.upd_valid_i && (u_stale || (bp.upd_pred_target_i != u_actual));

   assign bp.mispredict_o  = u_misp;
   assign bp.redirect_pc_o = u_stale ? u_seq_pc : u_actual;
   assign bp.branch_cnt_o  = branch_cnt_q;
   assign bp.mispred_cnt_o = mispred_cnt_q;

   assign ctr_cur   = ctr_q[u_idx];
   assign ctr_alloc = bp.upd_is_jump_i ? CTR_MAX : CTR_WEAK;

   always_comb begin
      ctr_nxt = ctr_cur;
      if (bp.upd_is_jump_i) begin
         ctr_nxt = CTR_MAX;
      end else if (bp.upd_taken_i) begin
         if (ctr_cur != CTR_MAX) ctr_nxt = ctr_cur + CTR_W'(1);
      end else begin
         if (ctr_cur != '0) ctr_nxt = ctr_cur - CTR_W'(1);
      end
   end

   // Tag and target are not reset: valid gates them.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         valid_q       <= '0;
         jmp_q         <= '0;
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            ctr_q[i] <= '0;
         end
      end else begin
         if (u_ctrl && (branch_cnt_q != '1)) branch_cnt_q <= branch_cnt_q + 32'd1;
         if (u_misp && (mispred_cnt_q != '1)) mispred_cnt_q <= mispred_cnt_q + 32'd1;
         if (u_train) begin
            if (u_hit) begin
               ctr_q[u_idx] <= ctr_nxt;
               if (bp.upd_taken_i) tgt_q[u_idx] <= bp.upd_target_i[31:2];
            end else if (bp.upd_taken_i) begin
               valid_q[u_idx] <= 1'b1;
               tag_q[u_idx]   <= u_tag;
               jmp_q[u_idx]   <= bp.upd_is_jump_i;
               tgt_q[u_idx]   <= bp.upd_target_i[31:2];
               ctr_q[u_idx]   <= ctr_alloc;
            end
         end else if (PRED_MODE && u_stale && u_hit) begin
            valid_q[u_idx] <= 1'b0;
         end
      end
   end

   // PC bits outside the index/tag fields and target alignment bits carry no state.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{bp.pc_if_i, bp.upd_pc_i, bp.upd_target_i};

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: one dynamic and one static instance share
// the same stimulus; a table model is compared on every negative edge, and directed
// literal expectations pin the model.
module tb_branch_predictor;
   localparam int ENTRIES = 16;
   localparam int TAG_W   = 8;
   localparam int CTR_W   = 2;
   localparam int IDX_W   = 4;
   localparam int CMAX    = (1 << CTR_W) - 1;
   localparam int CWEAK   = 1 << (CTR_W - 1);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   bit   chk_en = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   branch_predictor_if bif1 ();
   branch_predictor_if bif0 ();

   branch_predictor #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .CTR_W(CTR_W), .PRED_MODE(1'b1)) dut1 (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bp    (bif1)
   );

   branch_predictor #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .CTR_W(CTR_W), .PRED_MODE(1'b0)) dut0 (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bp    (bif0)
   );

   // ---------------- model state ----------------
   bit          m_valid [ENTRIES];
   int          m_tag   [ENTRIES];
   bit          m_jmp   [ENTRIES];
   logic [31:0] m_tgt   [ENTRIES];
   int          m_ctr   [ENTRIES];
   logic [31:0] m_bcnt;
   logic [31:0] m_mcnt;

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 2) % ENTRIES);
   endfunction

   function automatic int tag_of(input logic [31:0] pc);
      return int'((pc >> (2 + IDX_W)) % (1 << TAG_W));
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic look(input logic [31:0] pc);
      bif1.pc_if_i = pc;
      bif0.pc_if_i = pc;
   endtask

   task automatic upd(input logic [31:0] pc, input bit br, input bit jmp, input bit tk,
                      input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
      bif1.upd_valid_i = 1'b1;        bif0.upd_valid_i = 1'b1;
      bif1.upd_pc_i = pc;             bif0.upd_pc_i = pc;
      bif1.upd_is_branch_i = br;      bif0.upd_is_branch_i = br;
      bif1.upd_is_jump_i = jmp;       bif0.upd_is_jump_i = jmp;
      bif1.upd_taken_i = tk;          bif0.upd_taken_i = tk;
      bif1.upd_target_i = tgt;        bif0.upd_target_i = tgt;
      bif1.upd_pred_taken_i = ptk;    bif0.upd_pred_taken_i = ptk;
      bif1.upd_pred_target_i = ptgt;  bif0.upd_pred_target_i = ptgt;
   endtask

   task automatic noupd();
      upd(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      bif1.upd_valid_i = 1'b0;
      bif0.upd_valid_i = 1'b0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // ---------------- compare + model (inputs are stable from posedge+1 to next posedge) ----
   logic [31:0] lpc, upc, e_tgt, e_red, actual;
   int          li, ui;
   bit          e_taken, u_hit, ctrl, stale, e_misp;

   initial begin : compare_and_model
      forever begin
         @(negedge clk);
         lpc     = bif1.pc_if_i;
         li      = idx_of(lpc);
         e_taken = m_valid[li] && (m_tag[li] == tag_of(lpc)) && (m_jmp[li] || m_ctr[li] >= CWEAK);
         e_tgt   = e_taken ? m_tgt[li] : lpc + 32'd4;

         upc    = bif1.upd_pc_i;
         ui     = idx_of(upc);
         u_hit  = m_valid[ui] && (m_tag[ui] == tag_of(upc));
         ctrl   = bif1.upd_valid_i && (bif1.upd_is_branch_i || bif1.upd_is_jump_i);
         stale  = bif1.upd_valid_i && !bif1.upd_is_branch_i && !bif1.upd_is_jump_i &&
                  bif1.upd_pred_taken_i;
         actual = bif1.upd_taken_i ? bif1.upd_target_i : upc + 32'd4;
         e_misp = bif1.upd_valid_i && (stale || bif1.upd_pred_target_i != actual);
         e_red  = stale ? upc + 32'd4 : actual;

         if (chk_en) begin
            check("dyn_pred_taken", {31'b0, bif1.pred_taken_o}, {31'b0, e_taken});
            check("dyn_pred_target", bif1.pred_target_o, e_tgt);
            check("dyn_mispredict", {31'b0, bif1.mispredict_o}, {31'b0, e_misp});
            check("dyn_redirect", bif1.redirect_pc_o, e_red);
            check("dyn_branch_cnt", bif1.branch_cnt_o, m_bcnt);
            check("dyn_mispred_cnt", bif1.mispred_cnt_o, m_mcnt);
            check("sta_pred_taken", {31'b0, bif0.pred_taken_o}, 32'd0);
            check("sta_pred_target", bif0.pred_target_o, lpc + 32'd4);
            check("sta_mispredict", {31'b0, bif0.mispredict_o}, {31'b0, e_misp});
            check("sta_redirect", bif0.redirect_pc_o, e_red);
            check("sta_branch_cnt", bif0.branch_cnt_o, m_bcnt);
            check("sta_mispred_cnt", bif0.mispred_cnt_o, m_mcnt);
         end

         // state as it will be after the coming rising edge
         if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
               m_valid[i] = 1'b0;
               m_jmp[i]   = 1'b0;
               m_ctr[i]   = 0;
            end
            m_bcnt = 32'd0;
            m_mcnt = 32'd0;
         end else begin
            if (ctrl && m_bcnt != 32'hFFFF_FFFF) m_bcnt = m_bcnt + 32'd1;
            if (e_misp && m_mcnt != 32'hFFFF_FFFF) m_mcnt = m_mcnt + 32'd1;
            if (ctrl && u_hit) begin
               if (bif1.upd_is_jump_i) m_ctr[ui] = CMAX;
               else if (bif1.upd_taken_i) m_ctr[ui] = (m_ctr[ui] < CMAX) ? m_ctr[ui] + 1 : CMAX;
               else m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
               if (bif1.upd_taken_i) m_tgt[ui] = bif1.upd_target_i & 32'hFFFF_FFFC;
            end else if (ctrl && bif1.upd_taken_i) begin
               m_valid[ui] = 1'b1;
               m_tag[ui]   = tag_of(upc);
               m_jmp[ui]   = bif1.upd_is_jump_i;
               m_tgt[ui]   = bif1.upd_target_i & 32'hFFFF_FFFC;
               m_ctr[ui]   = bif1.upd_is_jump_i ? CMAX : CWEAK;
            end else if (stale && u_hit) begin
               m_valid[ui] = 1'b0;
            end
         end
      end
   end

   // ---------------- directed sequence ----------------
   initial begin : stimulus
      noupd();
      look(32'h100);
      cyc();
      cyc();
      chk_en = 1'b1;
      rst_n  = 1'b1;
      #1;
      check("rst_taken", {31'b0, bif1.pred_taken_o}, 32'd0);
      check("rst_target", bif1.pred_target_o, 32'h104);
      check("rst_bcnt", bif1.branch_cnt_o, 32'd0);
      check("rst_mcnt", bif1.mispred_cnt_o, 32'd0);
      cyc();

      // first taken branch allocates; same-cycle lookup sees old contents
      upd(32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
      #1;
      check("alloc_misp", {31'b0, bif1.mispredict_o}, 32'd1);
      check("alloc_redirect", bif1.redirect_pc_o, 32'h80);
      check("alloc_same_cycle", {31'b0, bif1.pred_taken_o}, 32'd0);
      cyc();
      noupd();
      #1;
      check("alloc_taken", {31'b0, bif1.pred_taken_o}, 32'd1);
      check("alloc_target", bif1.pred_target_o, 32'h80);
      check("alloc_mcnt", bif1.mispred_cnt_o, 32'd1);
      check("alloc_bcnt", bif1.branch_cnt_o, 32'd1);
      check("static_no_train", {31'b0, bif0.pred_taken_o}, 32'd0);

      // ctr 2 -> 1 -> 0 -> 0
      upd(32'h100, 1, 0, 0, 32'h80, 1, 32'h80);
      #1;
      check("nt1_misp", {31'b0, bif1.mispredict_o}, 32'd1);
      check("nt1_redirect", bif1.redirect_pc_o, 32'h104);
      cyc();
      noupd();
      #1;
      check("nt1_pred", {31'b0, bif1.pred_taken_o}, 32'd0);
      check("nt1_target", bif1.pred_target_o, 32'h104);
      upd(32'h100, 1, 0, 0, 32'h80, 0, 32'h104);
      #1;
      check("nt2_misp", {31'b0, bif1.mispredict_o}, 32'd0);
      cyc();
      upd(32'h100, 1, 0, 0, 32'h80, 0, 32'h104);
      cyc();
      noupd();
      #1;
      check("nt3_hold", {31'b0, bif1.pred_taken_o}, 32'd0);
      // 0 -> 1 still not taken (a wrap to max would predict taken), 1 -> 2 taken
      upd(32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
      cyc();
      noupd();
      #1;
      check("t1_pred", {31'b0, bif1.pred_taken_o}, 32'd0);
      upd(32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
      cyc();
      noupd();
      #1;
      check("t2_pred", {31'b0, bif1.pred_taken_o}, 32'd1);
      check("t2_target", bif1.pred_target_o, 32'h80);

      // aliasing: 0x140 shares index 0 with 0x100
      look(32'h140);
      #1;
      check("alias_miss", {31'b0, bif1.pred_taken_o}, 32'd0);
      check("alias_target", bif1.pred_target_o, 32'h144);
      upd(32'h140, 1, 0, 1, 32'h400, 0, 32'h144);
      cyc();
      noupd();
      look(32'h100);
      #1;
      check("alias_evicted", {31'b0, bif1.pred_taken_o}, 32'd0);
      check("alias_evicted_tgt", bif1.pred_target_o, 32'h104);
      look(32'h140);
      #1;
      check("alias_new_tgt", bif1.pred_target_o, 32'h400);

      // JAL then JALR with a different target
      upd(32'h200, 0, 1, 1, 32'h300, 0, 32'h204);
      cyc();
      noupd();
      look(32'h200);
      #1;
      check("jal_taken", {31'b0, bif1.pred_taken_o}, 32'd1);
      check("jal_target", bif1.pred_target_o, 32'h300);
      upd(32'h200, 0, 1, 1, 32'h310, 1, 32'h300);
      #1;
      check("jalr_misp", {31'b0, bif1.mispredict_o}, 32'd1);
      check("jalr_redirect", bif1.redirect_pc_o, 32'h310);
      cyc();
      noupd();
      #1;
      check("jalr_target", bif1.pred_target_o, 32'h310);

      // stale entry: non-control instruction predicted taken
      upd(32'h200, 0, 0, 0, 32'h0, 1, 32'h310);
      #1;
      check("stale_misp", {31'b0, bif1.mispredict_o}, 32'd1);
      check("stale_redirect", bif1.redirect_pc_o, 32'h204);
      cyc();
      noupd();
      #1;
      check("stale_cleared", {31'b0, bif1.pred_taken_o}, 32'd0);
      check("stale_cleared_tgt", bif1.pred_target_o, 32'h204);

      // plain instruction and invalid slot never mispredict
      upd(32'h500, 0, 0, 0, 32'h0, 0, 32'h504);
      #1;
      check("plain_misp", {31'b0, bif1.mispredict_o}, 32'd0);
      bif1.upd_valid_i = 1'b0;
      bif0.upd_valid_i = 1'b0;
      bif1.upd_pred_target_i = 32'h999;
      bif0.upd_pred_target_i = 32'h999;
      #1;
      check("invalid_misp", {31'b0, bif1.mispredict_o}, 32'd0);
      cyc();
      noupd();
      #1;
      check("cnt_branch", bif1.branch_cnt_o, 32'd9);
      check("cnt_mispred", bif1.mispred_cnt_o, 32'd8);
      check("cnt_branch_sta", bif0.branch_cnt_o, 32'd9);
      check("cnt_mispred_sta", bif0.mispred_cnt_o, 32'd8);

      // reset with a simultaneous update: reset wins
      rst_n = 1'b0;
      upd(32'h300, 1, 0, 1, 32'h40, 0, 32'h304);
      #1;
      check("rst_misp_comb", {31'b0, bif1.mispredict_o}, 32'd1);
      cyc();
      rst_n = 1'b1;
      noupd();
      look(32'h300);
      #1;
      check("rst_no_alloc", {31'b0, bif1.pred_taken_o}, 32'd0);
      check("rst_no_alloc_tgt", bif1.pred_target_o, 32'h304);
      check("rst_bcnt2", bif1.branch_cnt_o, 32'd0);
      check("rst_mcnt2", bif1.mispred_cnt_o, 32'd0);
      look(32'h140);
      #1;
      check("rst_all_miss", {31'b0, bif1.pred_taken_o}, 32'd0);

      // static mode never trains while dynamic mode does
      look(32'h300);
      upd(32'h300, 1, 0, 1, 32'h40, 0, 32'h304);
      cyc();
      cyc();
      noupd();
      #1;
      check("dyn_trained", {31'b0, bif1.pred_taken_o}, 32'd1);
      check("dyn_trained_tgt", bif1.pred_target_o, 32'h40);
      check("sta_untrained", {31'b0, bif0.pred_taken_o}, 32'd0);
      check("sta_untrained_tgt", bif0.pred_target_o, 32'h304);
      check("sta_mcnt", bif0.mispred_cnt_o, 32'd2);
      cyc();
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
